picorv32_trace_drain: RTL and testbench
=======================================

# picorv32_trace_drain

Reader for the PicoRV32 trace buffer. On a start pulse it snapshots the buffer's write pointer and trace count, then reads the buffer's 128-bit memory port row by row. It unpacks the two 36-bit traces per row and streams the valid traces, oldest first, on a valid/ready interface towards the TCU upload path. It is the consumer side of the trace capture buffer and sits beside it in the accelerator domain.

## Interface
- TRACE_BASEADDR, 32'h00100000, byte base address of trace buffer
- TRACE_SIZE, 'h2000, buffer bytes; 8 bytes per trace → 1024 traces, 512 rows
- PICO_MEM_ADDR_SIZE, 32, address/pointer width
- ASM_MEM_DATA_SIZE, 128, memory read data width
- Reset: reset_n_i, asynchronous, active-low. Clock: clk_i.
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- start_i  in  1  single-cycle drain request; honoured only in IDLE
- trace_ptr_i  in  PICO_MEM_ADDR_SIZE  next write trace index from buffer (low 10 bits used)
- trace_count_i  in  PICO_MEM_ADDR_SIZE  stored traces, saturates at 1024 (low 11 bits used)
- busy_o  out  1  high from the cycle after an accepted start until DONE exits
- done_o  out  1  one-cycle pulse when drain completes
- mem_en_o  out  1  buffer read enable
- mem_addr_o  out  PICO_MEM_ADDR_SIZE  byte address of the row
- mem_rdata_i  in  ASM_MEM_DATA_SIZE  row data, valid the cycle after mem_en_o; [35:0] even trace, [99:64] odd trace
- out_valid_o  out  1  trace word valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  36  trace word
- out_last_o  out  1  marks final word of drain

## Operation
- States: IDLE, READ, WAIT, EMIT, DONE.
- IDLE + start_i: latch N = min(trace_count_i, 1024) and idx = (trace_ptr_i − N) mod 1024; rem = N. Go to DONE if N == 0, else go to READ.
- READ: mem_en_o=1, mem_addr_o = TRACE_BASEADDR + (idx>>1)<<4. Go to WAIT.
- WAIT: capture mem_rdata_i into the row register. Go to EMIT.
- EMIT: out_data_o = lane idx[0] of the row register. out_last_o = (rem == 1). On out_valid_o && out_ready_i: idx = idx+1 mod 1024, rem−1.
  - If rem becomes 0, go to DONE.
  - Else if new idx is even (row crossed), go to READ.
  - Else stay in EMIT.
- DONE: done_o=1 for one cycle, then go to IDLE.
- Width rules: idx 10 bits with natural wrap 1023→0; rem 11 bits; address arithmetic 32-bit modulo.
- Snapshot semantics: ptr and count are sampled only at start. Later writer activity is not tracked. Software disables tracing before start. Rows overwritten mid-drain are emitted as read.
- start_i while busy: ignored, no effect.
- Reset mid-drain: immediate return to IDLE. Stream aborted, no done_o.

## Timing
- Reset values: busy_o, done_o, mem_en_o, out_valid_o, out_last_o all 0. mem_addr_o = TRACE_BASEADDR. out_data_o = 0.
- start at cycle T → READ at T+1 (mem_en_o) → WAIT at T+2 → first out_valid_o at T+3.
- N==0: done_o at T+1, busy_o never asserted.
- Throughput without backpressure: 2 traces per 4 cycles. The first row yields 1 trace if idx starts odd.
- Handshake: out_data_o and out_last_o are stable while out_valid_o && !out_ready_i. out_valid_o is never withdrawn before acceptance.
- mem_en_o is high exactly one cycle per row. Address is stable in that cycle.
- done_o occurs one cycle after the last handshake.

## Structure
- Shared package picorv32_trace_pkg holds:
  - TRACE_IDX_W=10 and TRACE_ROW_SHIFT=4
  - lane bit offsets 0 and 64 and TRACE_W=36
  - state enum
- The capture buffer reuses the same package constants.
- Single module. The row register and lane mux are inline; no sub-module.

## Test plan
- ptr=5, count=5 → 5 words idx 0..4. Reads of rows 0,1,2 at addresses 0x00100000/10/20. out_last_o on the 5th word. One done_o.
- ptr=3, count=1024 → start idx 3 (odd). The first row emits only its upper lane. Idx wraps 1023→0. 1024 words total, last = idx 2.
- ptr=7, count=2 → idx 5,6. Two reads at 0x00100020 and 0x00100030, each emitting one word.
- count=0 → done_o at T+1. No mem_en_o, no out_valid_o.
- Random out_ready_i stalls → data stable during stall. No word lost or duplicated. Extra start_i pulses while busy are ignored.
- Reset asserted mid-EMIT → all outputs 0 the same cycle. Next start behaves as fresh.

Source files
------------

// File: rtl/picorv32_trace_pkg.sv
// picorv32_trace_pkg
//   Constants and types shared by the trace capture buffer and the trace drain.
//   Sizes describe one 8-byte trace slot. Two slots make one 128-bit row.
//   Each row holds an even trace in bits [35:0] and an odd trace in [99:64].
package picorv32_trace_pkg;

    localparam int unsigned PICO_MEM_ADDR_SIZE = 32;
    localparam int unsigned ASM_MEM_DATA_SIZE  = 128;

    localparam logic [PICO_MEM_ADDR_SIZE-1:0] TRACE_BASEADDR = 32'h0010_0000;
    localparam logic [PICO_MEM_ADDR_SIZE-1:0] TRACE_SIZE     = 32'h0000_2000;

    localparam int unsigned TRACE_IDX_W     = 10;   // 1024 trace slots
    localparam int unsigned TRACE_CNT_W     = 11;   // 0..1024 inclusive
    localparam int unsigned TRACE_DEPTH     = 1 << TRACE_IDX_W;
    localparam int unsigned TRACE_ROW_SHIFT = 4;    // 16 bytes per row
    localparam int unsigned TRACE_W         = 36;
    localparam int unsigned TRACE_LANE0_LSB = 0;
    localparam int unsigned TRACE_LANE1_LSB = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } drain_state_e;

    // Byte address of the row that holds trace slot idx.
    function automatic logic [PICO_MEM_ADDR_SIZE-1:0] trace_row_addr(
        input logic [TRACE_IDX_W-1:0] idx
    );
        logic [PICO_MEM_ADDR_SIZE-1:0] row;
        row = PICO_MEM_ADDR_SIZE'(idx >> 1);
        return TRACE_BASEADDR + (row << TRACE_ROW_SHIFT);
    endfunction

endpackage

// File: rtl/picorv32_trace_drain.sv
// picorv32_trace_drain
//   Drains the PicoRV32 trace buffer oldest-first onto a valid/ready stream.
//   A start pulse in IDLE snapshots the write pointer and the trace count.
//   The drain then reads one 128-bit row at a time and emits the row's
//   trace lanes, starting at the lane of the current index.
//
//   Ports
//     clk_i, reset_n_i     clock, async active-low reset
//     start_i              drain request, only honoured in IDLE
//     trace_ptr_i          next write slot of the buffer (low 10 bits used)
//     trace_count_i        traces stored, clamped to 1024
//     busy_o, done_o       drain in progress / one-cycle completion pulse
//     mem_en_o, mem_addr_o row read request (one cycle per row)
//     mem_rdata_i          row data, valid the cycle after mem_en_o
//     out_valid_o/out_ready_i/out_data_o/out_last_o  trace stream
module picorv32_trace_drain
    import picorv32_trace_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    input  logic [PICO_MEM_ADDR_SIZE-1:0] trace_ptr_i,
    input  logic [PICO_MEM_ADDR_SIZE-1:0] trace_count_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          mem_en_o,
    output logic [PICO_MEM_ADDR_SIZE-1:0] mem_addr_o,
    input  logic [ASM_MEM_DATA_SIZE-1:0]  mem_rdata_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [TRACE_W-1:0]            out_data_o,
    output logic                          out_last_o
);

    drain_state_e           state_q, state_d;
    logic [TRACE_IDX_W-1:0] idx_q,   idx_d;
    logic [TRACE_CNT_W-1:0] rem_q,   rem_d;
    logic [TRACE_W-1:0]     lane0_q, lane0_d;
    logic [TRACE_W-1:0]     lane1_q, lane1_d;
    logic                   busy_q,  busy_d;

    logic [TRACE_CNT_W-1:0] n_clamp;
    logic [TRACE_IDX_W-1:0] idx_inc;
    logic [TRACE_W-1:0]     lane_sel;

    // Only the two trace lanes of a row and the pointer's slot bits matter.
    logic unused_bits;
    assign unused_bits = ^{trace_ptr_i[PICO_MEM_ADDR_SIZE-1:TRACE_IDX_W],
                           mem_rdata_i[TRACE_LANE1_LSB-1:TRACE_W],
                           mem_rdata_i[ASM_MEM_DATA_SIZE-1:TRACE_LANE1_LSB+TRACE_W]};

    // The count saturates at the depth. The full width is compared so that
    // a larger count cannot alias to a small one.
    assign n_clamp = (trace_count_i > PICO_MEM_ADDR_SIZE'(TRACE_DEPTH))
                   ? TRACE_CNT_W'(TRACE_DEPTH)
                   : trace_count_i[TRACE_CNT_W-1:0];

    assign idx_inc  = idx_q + 1'b1;
    assign lane_sel = idx_q[0] ? lane1_q : lane0_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        lane0_d = lane0_q;
        lane1_d = lane1_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rem_d = n_clamp;
                    // Oldest slot. A full buffer (N=1024) wraps to ptr itself.
                    idx_d = trace_ptr_i[TRACE_IDX_W-1:0] - n_clamp[TRACE_IDX_W-1:0];
                    if (n_clamp == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                lane0_d = mem_rdata_i[TRACE_LANE0_LSB +: TRACE_W];
                lane1_d = mem_rdata_i[TRACE_LANE1_LSB +: TRACE_W];
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready_i) begin
                    idx_d = idx_inc;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == TRACE_CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (!idx_inc[0]) begin
                        // The odd lane was just emitted, so fetch the next row.
                        state_d = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            lane0_q <= '0;
            lane1_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
            busy_q  <= busy_d;
        end
    end

    // Every output is decoded from state and registers only, so an async
    // reset clears the whole interface in the same cycle.
    assign busy_o      = busy_q;
    assign done_o      = (state_q == ST_DONE);
    assign mem_en_o    = (state_q == ST_READ);
    assign mem_addr_o  = trace_row_addr(idx_q);
    assign out_valid_o = (state_q == ST_EMIT);
    assign out_data_o  = out_valid_o ? lane_sel : '0;
    assign out_last_o  = out_valid_o && (rem_q == TRACE_CNT_W'(1));

endmodule

// File: tb/tb_picorv32_trace_drain.sv
module tb_picorv32_trace_drain;
    import picorv32_trace_pkg::*;

    logic         clk_i = 1'b0;
    logic         reset_n_i = 1'b0;
    logic         start_main = 1'b0;
    logic         start_junk = 1'b0;
    logic [31:0]  trace_ptr_i = '0;
    logic [31:0]  trace_count_i = '0;
    logic         busy_o, done_o, mem_en_o, out_valid_o, out_last_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_rdata_i = '0;
    logic         out_ready_i = 1'b1;
    logic [35:0]  out_data_o;

    picorv32_trace_drain dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .start_i      (start_main | start_junk),
        .trace_ptr_i  (trace_ptr_i),
        .trace_count_i(trace_count_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem_en_o     (mem_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Buffer memory: one row per 16 bytes, synchronous read.
    logic [127:0] mem [512];
    always @(posedge clk_i) begin
        logic [31:0] off;
        off = mem_addr_o - TRACE_BASEADDR;
        if (mem_en_o) mem_rdata_i <= mem[off[12:4]];
    end

    typedef struct { logic [35:0] data; logic last; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int tests = 0;
    int fails = 0;

    bit stall_en = 0;
    bit junk_en = 0;
    bit skip_done_chk = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic randomize_mem();
        for (int r = 0; r < 512; r++) mem[r] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Reference: the last N written slots, oldest first, where N is the
    // count clamped to the buffer depth. A new row is fetched for the first
    // trace and for every even slot.
    task automatic push_drain(input logic [31:0] ptr, input logic [31:0] count);
        int n, s, i;
        exp_t e;
        n = (count > 1024) ? 1024 : int'(count);
        s = (int'(ptr & 32'd1023) - n + 1024) % 1024;
        for (int k = 0; k < n; k++) begin
            i = (s + k) % 1024;
            if (k == 0 || i % 2 == 0) addr_q.push_back(32'h0010_0000 + 32'(i / 2) * 32'd16);
            e.data = (i % 2 == 0) ? mem[i / 2][35:0] : mem[i / 2][99:64];
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    // Returns one cycle after the start pulse is sampled.
    task automatic do_start(input logic [31:0] ptr, input logic [31:0] count);
        @(posedge clk_i); #1;
        trace_ptr_i   = ptr;
        trace_count_i = count;
        skip_done_chk = (count == 0);
        push_drain(ptr, count);
        start_main = 1'b1;
        @(posedge clk_i); #1;
        start_main = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk_i);
            if (done_o) begin seen = 1; break; end
        end
        check({name, "_done_seen"}, 128'(seen), 128'd1);
        check({name, "_words_left"}, 128'(exp_q.size()), 128'd0);
        check({name, "_reads_left"}, 128'(addr_q.size()), 128'd0);
        skip_done_chk = 0;
    endtask

    always @(posedge clk_i) begin
        #1;
        out_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        start_junk  = junk_en && busy_o && !done_o && ($urandom_range(0, 7) == 0);
    end

    // Monitor: compares reads, words, stall stability and done timing.
    bit          prev_stall = 0;
    logic [36:0] prev_word;
    bit          exp_done_next = 0;
    always @(negedge clk_i) begin
        exp_t e;
        if (!reset_n_i) begin
            prev_stall    = 0;
            exp_done_next = 0;
        end else begin
            if (mem_en_o) begin
                if (addr_q.size() == 0) check("unexpected_read", 128'(mem_addr_o), 128'hFFFF_FFFF_FFFF);
                else check("read_addr", 128'(mem_addr_o), 128'(addr_q.pop_front()));
            end
            if (prev_stall)
                check("stall_hold", 128'({out_valid_o, out_last_o, out_data_o}), 128'({1'b1, prev_word}));
            prev_stall = out_valid_o && !out_ready_i;
            prev_word  = {out_last_o, out_data_o};
            if (exp_done_next) begin
                check("done_after_last", 128'(done_o), 128'd1);
                exp_done_next = 0;
            end else if (done_o && !skip_done_chk) begin
                check("spurious_done", 128'(done_o), 128'd0);
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 128'({out_last_o, out_data_o}), 128'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("word", 128'({out_last_o, out_data_o}), 128'({e.last, e.data}));
                    if (e.last) exp_done_next = 1;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"}, 128'({busy_o, done_o, mem_en_o, out_valid_o, out_last_o}), 128'd0);
        check({name, "_addr"}, 128'(mem_addr_o), 128'(TRACE_BASEADDR));
        check({name, "_data"}, 128'(out_data_o), 128'd0);
    endtask

    initial begin
        bit seen;
        randomize_mem();

        // Reset state
        repeat (3) @(posedge clk_i);
        #1 check_idle_outputs("reset");
        reset_n_i = 1'b1;

        // ptr=5 count=5: rows 0,1,2, with the latency checked cycle by cycle
        do_start(32'd5, 32'd5);
        @(negedge clk_i);
        check("t1_read_cycle", 128'({busy_o, mem_en_o, out_valid_o}), 128'b110);
        @(negedge clk_i);
        check("t1_wait_cycle", 128'({mem_en_o, out_valid_o}), 128'b00);
        @(negedge clk_i);
        check("t1_first_valid", 128'(out_valid_o), 128'd1);
        wait_done("t1");

        // ptr=7 count=2: idx 5 (odd lane of row 2) then idx 6 (row 3)
        randomize_mem();
        do_start(32'd7, 32'd2);
        wait_done("t2");

        // count=0: done at T+1, no activity
        do_start(32'd9, 32'd0);
        @(negedge clk_i);
        check("t3_done_t1", 128'({done_o, busy_o}), 128'b10);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            check("t3_quiet", 128'({done_o, busy_o, mem_en_o, out_valid_o}), 128'd0);
        end
        skip_done_chk = 0;

        // Full buffer from an odd start, with wrap, stalls and stray starts
        randomize_mem();
        stall_en = 1; junk_en = 1;
        do_start(32'd3, 32'd1024);
        wait_done("t4");

        // Random drains
        for (int r = 0; r < 6; r++) begin
            randomize_mem();
            do_start($urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1100) : $urandom_range(1, 80));
            wait_done("rand");
        end
        junk_en = 0;

        // Reset during EMIT aborts the stream with no done
        randomize_mem();
        do_start(32'd100, 32'd50);
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk_i);
            if (out_valid_o) begin seen = 1; break; end
        end
        check("t5_reached_emit", 128'(seen), 128'd1);
        @(posedge clk_i); #2;
        reset_n_i = 1'b0;
        #1 check_idle_outputs("t5_reset");
        exp_q.delete();
        addr_q.delete();
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        stall_en = 0;
        do_start(32'd20, 32'd6);
        wait_done("t5_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
